// File: rtl/el2_pkg.sv
// Shared types for the EL2 decode writeback path.
package el2_pkg;

    localparam int unsigned GPR_AW = 5;
    localparam int unsigned GPR_DW = 32;

    // One pending GPR write: destination register and result data.
    typedef struct packed {
        logic [GPR_AW-1:0] addr;
        logic [GPR_DW-1:0] data;
    } el2_gpr_wb_pkt_t;

endpackage

// File: rtl/rvdff.sv
// Plain flop vector with asynchronous active-low reset.
module rvdff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             clk,
    input  logic             rst_l,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) dout <= '0;
        else        dout <= din;
    end

endmodule

// File: rtl/rvdffe.sv
// Enable-gated flop vector; scan_mode forces the clock enable on as the gater would.
module rvdffe #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             clk,
    input  logic             rst_l,
    input  logic             scan_mode,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)                dout <= '0;
        else if (en | scan_mode)   dout <= din;
    end

endmodule

// File: rtl/el2_dec_gpr_wbq.sv
// Writeback queue merging load and divider results onto GPR write port 2.
module el2_dec_gpr_wbq
    import el2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        ld_wb_valid,
    input  logic [4:0]  ld_wb_addr,
    input  logic [31:0] ld_wb_data,
    output logic        ld_wb_ready,
    input  logic        div_wb_valid,
    input  logic [4:0]  div_wb_addr,
    input  logic [31:0] div_wb_data,
    output logic        div_wb_ready,
    input  logic        wr_port_free,
    output logic        wen2,
    output logic [4:0]  waddr2,
    output logic [31:0] wd2,
    input  logic [4:0]  raddr0,
    input  logic [4:0]  raddr1,
    output logic        pend0,
    output logic        pend1,
    output logic [3:0]  wbq_cnt,
    input  logic        scan_mode
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    logic [PW-1:0]   wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt, div_slot;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            ld_push, div_push, pop;
    logic [DEPTH-1:0] entry_en, entry_vld;
    el2_gpr_wb_pkt_t ld_pkt, div_pkt, head;
    el2_gpr_wb_pkt_t entry_din [DEPTH];
    el2_gpr_wb_pkt_t entry     [DEPTH];

    assign ld_pkt  = '{addr: ld_wb_addr,  data: ld_wb_data};
    assign div_pkt = '{addr: div_wb_addr, data: div_wb_data};

    // Readiness depends on registered occupancy only; the load claims the first free slot.
    always_comb begin
        ld_wb_ready  = cnt < CW'(DEPTH);
        div_wb_ready = ld_wb_valid ? (cnt <= CW'(DEPTH - 2)) : (cnt < CW'(DEPTH));
        ld_push      = ld_wb_valid  & ld_wb_ready  & (ld_wb_addr  != 5'd0);
        div_push     = div_wb_valid & div_wb_ready & (div_wb_addr != 5'd0);
        pop          = (cnt != '0) & wr_port_free;
        div_slot     = wr_ptr + PW'(ld_push);
        wr_ptr_nxt   = wr_ptr + PW'(ld_push) + PW'(div_push);
        rd_ptr_nxt   = rd_ptr + PW'(pop);
        cnt_nxt      = cnt + CW'(ld_push) + CW'(div_push) - CW'(pop);
    end

    rvdff #(.WIDTH(PW)) u_wr_ptr (.din(wr_ptr_nxt), .clk(clk), .rst_l(rst_l), .dout(wr_ptr));
    rvdff #(.WIDTH(PW)) u_rd_ptr (.din(rd_ptr_nxt), .clk(clk), .rst_l(rst_l), .dout(rd_ptr));
    rvdff #(.WIDTH(CW)) u_cnt    (.din(cnt_nxt),    .clk(clk), .rst_l(rst_l), .dout(cnt));

    // Storage is never reset; validity comes from the entry's distance to the read pointer.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic          ld_hit, div_hit;
        logic [PW-1:0] offs;

        assign ld_hit       = ld_push  & (wr_ptr   == PW'(i));
        assign div_hit      = div_push & (div_slot == PW'(i));
        assign entry_en[i]  = ld_hit | div_hit;
        assign entry_din[i] = ld_hit ? ld_pkt : div_pkt;
        assign offs         = PW'(i) - rd_ptr;
        assign entry_vld[i] = CW'(offs) < cnt;

        rvdffe #(.WIDTH($bits(el2_gpr_wb_pkt_t))) u_entry (
            .din       (entry_din[i]),
            .en        (entry_en[i]),
            .clk       (clk),
            .rst_l     (1'b1),
            .scan_mode (scan_mode),
            .dout      (entry[i])
        );
    end

    assign head    = entry[rd_ptr];
    assign wen2    = pop;
    assign waddr2  = pop ? head.addr : 5'd0;
    assign wd2     = pop ? head.data : 32'd0;
    assign wbq_cnt = cnt;

    // Hazard query over queued entries only; x0 is never pending.
    always_comb begin
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (entry[i].addr == raddr0)) pend0 = 1'b1;
            if (entry_vld[i] && (entry[i].addr == raddr1)) pend1 = 1'b1;
        end
        pend0 = pend0 & (raddr0 != 5'd0);
        pend1 = pend1 & (raddr1 != 5'd0);
    end

endmodule

// File: tb/tb_el2_dec_gpr_wbq.sv
// Self-checking bench: directed scenarios then random traffic against a queue model.
module tb_el2_dec_gpr_wbq;
    import el2_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk, rst_l;
    logic        ld_wb_valid, div_wb_valid, wr_port_free, scan_mode;
    logic [4:0]  ld_wb_addr, div_wb_addr, raddr0, raddr1, waddr2;
    logic [31:0] ld_wb_data, div_wb_data, wd2;
    logic        ld_wb_ready, div_wb_ready, wen2, pend0, pend1;
    logic [3:0]  wbq_cnt;

    int n_cmp = 0;
    int n_err = 0;
    el2_gpr_wb_pkt_t mq[$];

    el2_dec_gpr_wbq #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_l(rst_l),
        .ld_wb_valid(ld_wb_valid), .ld_wb_addr(ld_wb_addr), .ld_wb_data(ld_wb_data),
        .ld_wb_ready(ld_wb_ready),
        .div_wb_valid(div_wb_valid), .div_wb_addr(div_wb_addr), .div_wb_data(div_wb_data),
        .div_wb_ready(div_wb_ready),
        .wr_port_free(wr_port_free), .wen2(wen2), .waddr2(waddr2), .wd2(wd2),
        .raddr0(raddr0), .raddr1(raddr1), .pend0(pend0), .pend1(pend1),
        .wbq_cnt(wbq_cnt), .scan_mode(scan_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Check every output against the model for the currently applied inputs.
    task automatic check_outputs(output logic exp_lr, output logic exp_dr, output logic exp_wen);
        int sz;
        logic p0, p1;
        sz      = mq.size();
        exp_lr  = (sz < int'(DEPTH));
        exp_dr  = ld_wb_valid ? (sz <= int'(DEPTH) - 2) : (sz < int'(DEPTH));
        exp_wen = (sz != 0) && wr_port_free;
        p0 = 1'b0;
        p1 = 1'b0;
        foreach (mq[k]) begin
            if (mq[k].addr == raddr0 && raddr0 != 5'd0) p0 = 1'b1;
            if (mq[k].addr == raddr1 && raddr1 != 5'd0) p1 = 1'b1;
        end
        chk("ld_wb_ready",  32'(ld_wb_ready),  32'(exp_lr));
        chk("div_wb_ready", 32'(div_wb_ready), 32'(exp_dr));
        chk("wen2",         32'(wen2),         32'(exp_wen));
        chk("waddr2",       32'(waddr2),       exp_wen ? 32'(mq[0].addr) : 32'd0);
        chk("wd2",          wd2,               exp_wen ? mq[0].data : 32'd0);
        chk("pend0",        32'(pend0),        32'(p0));
        chk("pend1",        32'(pend1),        32'(p1));
        chk("wbq_cnt",      32'(wbq_cnt),      32'(sz));
    endtask

    // Apply one cycle of inputs, check, advance the model, then cross the clock edge.
    task automatic step(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic dv, input logic [4:0] da, input logic [31:0] dd,
                        input logic fr, input logic [4:0] r0, input logic [4:0] r1);
        logic lr, dr, wn;
        ld_wb_valid = lv;  ld_wb_addr = la;  ld_wb_data = ld;
        div_wb_valid = dv; div_wb_addr = da; div_wb_data = dd;
        wr_port_free = fr; raddr0 = r0; raddr1 = r1;
        #1;
        check_outputs(lr, dr, wn);
        if (wn) void'(mq.pop_front());
        if (lv && lr && la != 5'd0) mq.push_back('{addr: la, data: ld});
        if (dv && dr && da != 5'd0) mq.push_back('{addr: da, data: dd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic fr, input logic [4:0] r0, input logic [4:0] r1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, fr, r0, r1);
    endtask

    // Assert reset between edges and check outputs before any clock edge arrives.
    task automatic do_reset();
        logic lr, dr, wn;
        rst_l = 1'b0;
        wr_port_free = 1'b1;
        ld_wb_valid = 1'b0;
        div_wb_valid = 1'b0;
        raddr0 = 5'd3;
        raddr1 = 5'd4;
        #1;
        mq.delete();
        check_outputs(lr, dr, wn);
        @(negedge clk);
        rst_l = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_l = 1'b0;
        scan_mode = 1'b0;
        ld_wb_valid = 1'b0; ld_wb_addr = '0; ld_wb_data = '0;
        div_wb_valid = 1'b0; div_wb_addr = '0; div_wb_data = '0;
        wr_port_free = 1'b0; raddr0 = '0; raddr1 = '0;
        #2;
        do_reset();

        // Single load, written the next cycle.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0);
        idle(1'b1, 5'd5, 5'd6);
        idle(1'b1, 5'd5, 5'd0);

        // Load and divider to the same register, drained in order.
        step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b1, 5'd7, 5'd0);
        idle(1'b1, 5'd7, 5'd0);
        idle(1'b1, 5'd7, 5'd0);
        idle(1'b1, 5'd7, 5'd0);

        // Fill with the port busy, then drain back-to-back.
        for (int i = 1; i <= 4; i++)
            step(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd9);
        step(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13, 1'b0, 5'd3, 5'd9);
        for (int i = 0; i < 5; i++) idle(1'b1, 5'd1, 5'd4);

        // Occupancy three: load wins, divider waits for space.
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'(20 + i), 32'h200 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd21, 5'd0);
        step(1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB, 1'b0, 5'd10, 5'd11);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB, 1'b0, 5'd10, 5'd11);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB, 1'b1, 5'd10, 5'd11);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB, 1'b1, 5'd10, 5'd11);
        for (int i = 0; i < 5; i++) idle(1'b1, 5'd11, 5'd0);

        // Writes to x0 complete the handshake but are dropped.
        step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 1'b1, 5'd0, 5'd0);
        idle(1'b1, 5'd0, 5'd0);

        // Reset with entries queued; nothing must be written afterwards.
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'(3 + i), 32'h300 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd4);
        do_reset();
        for (int i = 0; i < 3; i++) idle(1'b1, 5'd3, 5'd4);

        // Random traffic over a small register range for frequent hazards.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 2) != 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 10; i++) idle(1'b1, 5'd1, 5'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/el2_dec_gpr_wbq.md
EL2_DEC_GPR_WBQ -- requirements
Module: el2_dec_gpr_wbq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are 2, 4 and 8.
REQ-002 SHALL have port clk  input  1  core clock; the only clock, and all state updates on its rising edge.
REQ-003 SHALL have port rst_l  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ld_wb_valid  input  1  load-return writeback request.
REQ-005 SHALL have port ld_wb_addr  input  5  load destination GPR.
REQ-006 SHALL have port ld_wb_data  input  32  load result data.
REQ-007 SHALL have port ld_wb_ready  output  1  load request accepted this cycle.
REQ-008 SHALL have port div_wb_valid  input  1  divider writeback request.
REQ-009 SHALL have port div_wb_addr  input  5  divider destination GPR.
REQ-010 SHALL have port div_wb_data  input  32  divider result data.
REQ-011 SHALL have port div_wb_ready  output  1  divider request accepted this cycle.
REQ-012 SHALL have port wr_port_free  input  1  GPR-file write port 2 is unused by the pipeline this cycle.
REQ-013 SHALL have port wen2  output  1  write enable toward the GPR file.
REQ-014 SHALL have port waddr2  output  5  write address toward the GPR file.
REQ-015 SHALL have port wd2  output  32  write data toward the GPR file.
REQ-016 SHALL have port raddr0 and raddr1  input  5 each  decode source registers for the hazard query.
REQ-017 SHALL have port pend0 and pend1  output  1 each  a queued write targets raddr0 or raddr1 respectively.
REQ-018 SHALL have port wbq_cnt  output  4  current occupancy.
REQ-019 SHALL have port scan_mode  input  1  passed to the flop cells.

Function
REQ-020 SHALL implement a circular FIFO of DEPTH entries (addr[4:0], data[31:0]) with read/write pointers and an occupancy counter.
REQ-021 SHALL handshake so that a transfer occurs when valid & ready; ready is combinational from the registered occupancy only, with no pop-through when full.
REQ-022 SHALL drive ld_wb_ready = (free >= 1).
REQ-023 SHALL drive div_wb_ready = (free >= 2) when ld_wb_valid is high, else (free >= 1), giving the load priority.
REQ-024 SHALL enqueue the load before the divider when both transfer in the same cycle, consuming two consecutive slots.
REQ-025 SHALL accept a request to addr 0 (handshake completes) without enqueueing it.
REQ-026 SHALL drive wen2 = ~empty & wr_port_free, with waddr2/wd2 taken from the head entry, and pop the head in the same cycle.
REQ-027 SHALL force waddr2/wd2 to 0 when wen2 is low.
REQ-028 SHALL have a minimum latency of 1 cycle: an entry accepted on edge N can drive wen2 in cycle N+1.
REQ-029 SHALL, on simultaneous push(es) and pop, update occupancy by pushes minus pop; occupancy never exceeds DEPTH and never underflows.
REQ-030 SHALL wrap both pointers modulo DEPTH.
REQ-031 SHALL drain entries with the same addr in FIFO order, so the last-enqueued value is the final architectural value.
REQ-032 SHALL drive pendX = OR over valid entries of (entry.addr == raddrX); it covers queue contents only, not same-cycle inputs, and raddr 0 always yields 0.
REQ-033 SHALL never drop or flush entries: every accepted nonzero-addr write is written exactly once.

Reset
REQ-034 SHALL, while rst_l is low, asynchronously clear pointers and occupancy, giving wen2=0, waddr2=0, wd2=0, pend0=pend1=0, wbq_cnt=0, ld_wb_ready=1, div_wb_ready=1.
REQ-035 SHALL leave entry data/addr storage un-reset; storage is enable-gated and qualified by occupancy.
REQ-036 SHALL discard the queue contents when reset is asserted mid-operation, with no writes issued after deassertion until new pushes occur.

Structure
REQ-037 SHALL take the entry type el2_gpr_wb_pkt_t {addr[4:0], data[31:0]} from el2_pkg.
REQ-038 SHALL implement storage with rvdffe per entry and pointers/counter with rvdff; no new sub-module is created.

Verification
REQ-039 SHALL cover: single load push x5=0xDEADBEEF with wr_port_free=1 -> next cycle wen2=1, waddr2=5, wd2=0xDEADBEEF, cnt returns to 0.
REQ-040 SHALL cover: ld x7=0x1 and div x7=0x2 pushed in the same cycle, port free -> two writes, x7=0x1 then x7=0x2, in order.
REQ-041 SHALL cover: wr_port_free=0 with 4 pushes (DEPTH=4) -> cnt=4, both readies 0, pend asserted for queued addrs; then free=1 -> 4 writes on consecutive cycles.
REQ-042 SHALL cover: occupancy 3 with ld and div both valid -> ld accepted, div_wb_ready=0, div held and accepted on a later cycle.
REQ-043 SHALL cover: push to addr 0 -> ready=1, cnt unchanged, no wen2.
REQ-044 SHALL cover: rst_l low with cnt=3 -> outputs immediately at reset values, and no wen2 after release.
